// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: one pipeline stage register with valid/ready handshake,
// Tnew countdown on capture, bubble insertion and flush to the exception PC.
// Optional macro PIPE_SKID_EN adds a skid entry, so in_ready comes straight
// from a flop and does not depend on out_ready. Without the macro the stage
// has one entry and in_ready depends combinationally on out_ready.
module pipe_stage_reg #(
  parameter int          DATA_W   = 64,
  parameter int          TNEW_W   = 2,
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] EXC_PC   = 32'h0000_4180
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              bubble,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [31:0]       in_pc,
  input  logic [TNEW_W-1:0] in_tnew,
  input  logic              in_dslot,
  input  logic [4:0]        in_exc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [31:0]       out_pc,
  output logic [TNEW_W-1:0] out_tnew,
  output logic              out_dslot,
  output logic [4:0]        out_exc
);

`ifdef PIPE_SKID_EN
  typedef enum logic [1:0] {ST_EMPTY = 2'd0, ST_FULL = 2'd1, ST_SKID = 2'd2} state_t;
`else
  typedef enum logic [1:0] {ST_EMPTY = 2'd0, ST_FULL = 2'd1} state_t;
`endif

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [31:0]       pc;
    logic [TNEW_W-1:0] tnew;
    logic              dslot;
    logic [4:0]        exc;
  } entry_t;

  // The producer's Tnew is one cycle closer to ready once it sits here.
  function automatic logic [TNEW_W-1:0] sat_dec(input logic [TNEW_W-1:0] t);
    return (t == '0) ? '0 : t - 1'b1;
  endfunction

  state_t state_q, state_d;
  entry_t main_q, main_d;
  entry_t cap;
  logic   up_xfer, dn_xfer;

`ifdef PIPE_SKID_EN
  entry_t skid_q, skid_d;
  logic   rdy_q, rdy_d;

  // A bubble takes over main this cycle, so nothing is accepted upstream.
  assign in_ready = rdy_q && !bubble;
`else
  // Accept only when the single entry empties this cycle.
  assign in_ready = (!out_valid || out_ready) && !bubble;
`endif

  assign out_valid = (state_q != ST_EMPTY);
  assign up_xfer   = in_valid && in_ready;
  assign dn_xfer   = out_valid && out_ready;

  assign out_data  = main_q.data;
  assign out_pc    = main_q.pc;
  assign out_tnew  = main_q.tnew;
  assign out_dslot = main_q.dslot;
  assign out_exc   = main_q.exc;

  // Next state and entry contents; flush beats bubble beats handshake.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
`ifdef PIPE_SKID_EN
    skid_d  = skid_q;
`endif
    cap = '{data: in_data, pc: in_pc, tnew: sat_dec(in_tnew),
            dslot: in_dslot, exc: in_exc};
    if (flush) begin
      state_d  = ST_EMPTY;
      main_d   = '0;
      main_d.pc = EXC_PC;
`ifdef PIPE_SKID_EN
      skid_d   = '0;
`endif
    end else if (bubble) begin
      // The bubble keeps PC and delay-slot tags so later stages still see
      // where the stalled instruction sits.
      state_d      = ST_EMPTY;
      main_d       = '0;
      main_d.pc    = in_pc;
      main_d.dslot = in_dslot;
`ifdef PIPE_SKID_EN
      skid_d       = '0;
`endif
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (up_xfer) begin
            main_d  = cap;
            state_d = ST_FULL;
          end
        end
        ST_FULL: begin
          if (up_xfer && dn_xfer) begin
            main_d = cap;
          end else if (dn_xfer) begin
            state_d = ST_EMPTY;
`ifdef PIPE_SKID_EN
          end else if (up_xfer) begin
            // Downstream is stalled, so park the new entry behind main.
            skid_d  = cap;
            state_d = ST_SKID;
`endif
          end
        end
`ifdef PIPE_SKID_EN
        ST_SKID: begin
          if (dn_xfer) begin
            main_d  = skid_q;
            skid_d  = '0;
            state_d = ST_FULL;
          end
        end
`endif
        default: state_d = ST_EMPTY;
      endcase
    end
  end

`ifdef PIPE_SKID_EN
  // in_ready is registered from the next state, so it does not depend on out_ready.
  always_comb begin
    rdy_d = (state_d != ST_SKID);
  end
`endif

  // State and entry registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_EMPTY;
      main_q     <= '0;
      main_q.pc  <= RESET_PC;
`ifdef PIPE_SKID_EN
      skid_q     <= '0;
      rdy_q      <= 1'b1;
`endif
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
`ifdef PIPE_SKID_EN
      skid_q     <= skid_d;
      rdy_q      <= rdy_d;
`endif
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: directed scenarios plus a random
// run against a queue-based reference model of the stage's contents.
module tb_pipe_stage_reg;

  localparam logic [31:0] RST_PC = 32'h0000_3000;
  localparam logic [31:0] EX_PC  = 32'h0000_4180;

  logic        clk = 1'b0;
  logic        rst, flush, bubble, in_valid, in_ready, out_valid, out_ready;
  logic [63:0] in_data, out_data;
  logic [31:0] in_pc, out_pc;
  logic [1:0]  in_tnew, out_tnew;
  logic        in_dslot, out_dslot;
  logic [4:0]  in_exc, out_exc;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [63:0] d;
    logic [31:0] pc;
    logic [1:0]  t;
    logic        ds;
    logic [4:0]  e;
  } ent_t;

  ent_t q[$];

  pipe_stage_reg dut (
    .clk(clk), .rst(rst), .flush(flush), .bubble(bubble),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_pc(in_pc), .in_tnew(in_tnew),
    .in_dslot(in_dslot), .in_exc(in_exc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_pc(out_pc), .out_tnew(out_tnew),
    .out_dslot(out_dslot), .out_exc(out_exc)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] dec_model(input logic [1:0] t);
    return (t == 2'd0) ? 2'd0 : 2'(t - 2'd1);
  endfunction

  task automatic idle_inputs();
    flush = 0; bubble = 0; in_valid = 0; out_ready = 0;
    in_data = '0; in_pc = '0; in_tnew = '0; in_dslot = 0; in_exc = '0;
  endtask

  // one clock edge; inputs were set before, outputs sampled 1 time unit after
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 0;
    step(); step();
    rst = 1;
    #1;
    total++; if (out_pc !== RST_PC) begin bad++; $display("FAIL reset_pc got=%h want=%h", out_pc, RST_PC); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", out_valid); end
    total++; if (out_tnew !== 2'd0) begin bad++; $display("FAIL reset_tnew got=%0d want=0", out_tnew); end
    total++; if (out_data !== 64'd0) begin bad++; $display("FAIL reset_data got=%h want=0", out_data); end
    total++; if (out_dslot !== 1'b0 || out_exc !== 5'd0) begin bad++; $display("FAIL reset_dslot_exc got=%b/%h want=0/0", out_dslot, out_exc); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
  endtask

  task automatic test_basic();
    @(negedge clk);
    in_valid = 1; in_tnew = 2'd2; in_pc = 32'h3004; in_data = 64'hDEAD_BEEF_0123_4567;
    in_exc = 5'd3; out_ready = 1;
    step();
    in_valid = 0;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL basic_valid got=%b want=1", out_valid); end
    total++; if (out_tnew !== 2'd1) begin bad++; $display("FAIL basic_tnew2 got=%0d want=1", out_tnew); end
    total++; if (out_pc !== 32'h3004) begin bad++; $display("FAIL basic_pc got=%h want=3004", out_pc); end
    total++; if (out_data !== 64'hDEAD_BEEF_0123_4567 || out_exc !== 5'd3) begin bad++; $display("FAIL basic_data got=%h/%h", out_data, out_exc); end
    step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_drain got=%b want=0", out_valid); end
    in_valid = 1; in_tnew = 2'd0; in_pc = 32'h3008;
    step();
    in_valid = 0;
    total++; if (out_tnew !== 2'd0 || out_valid !== 1'b1) begin bad++; $display("FAIL basic_tnew0 got=%0d/%b want=0/1", out_tnew, out_valid); end
    in_valid = 1; in_tnew = 2'd3; in_pc = 32'h300C;
    step();
    in_valid = 0;
    total++; if (out_tnew !== 2'd2 || out_pc !== 32'h300C) begin bad++; $display("FAIL basic_tnew3 got=%0d/%h want=2/300c", out_tnew, out_pc); end
    step();
    out_ready = 0;
  endtask

  task automatic test_backpressure();
    idle_inputs();
    @(negedge clk);
    in_valid = 1; in_pc = 32'hA000; in_data = 64'hA;
    step();
    in_pc = 32'hB000; in_data = 64'hB;
`ifdef PIPE_SKID_EN
    step();
    in_valid = 0;
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL skid_in_ready got=%b want=0", in_ready); end
    total++; if (out_pc !== 32'hA000 || out_valid !== 1'b1) begin bad++; $display("FAIL skid_head got=%h/%b want=a000/1", out_pc, out_valid); end
    out_ready = 1;
    step();
    total++; if (out_pc !== 32'hB000 || out_data !== 64'hB || out_valid !== 1'b1) begin bad++; $display("FAIL skid_second got=%h/%b want=b000/1", out_pc, out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL skid_ready_after got=%b want=1", in_ready); end
    step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL skid_drain got=%b want=0", out_valid); end
`else
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready got=%b want=0", in_ready); end
    out_ready = 1;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_in_ready_pass got=%b want=1", in_ready); end
    step();
    in_valid = 0;
    total++; if (out_pc !== 32'hB000 || out_valid !== 1'b1) begin bad++; $display("FAIL bp_second got=%h/%b want=b000/1", out_pc, out_valid); end
    step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_drain got=%b want=0", out_valid); end
`endif
    out_ready = 0;
  endtask

  task automatic test_bubble();
    idle_inputs();
    @(negedge clk);
    in_valid = 1; in_pc = 32'h3020; in_data = 64'h55; in_tnew = 2'd2; in_exc = 5'd7;
    step();
    bubble = 1; in_pc = 32'h3010; in_dslot = 1; in_tnew = 2'd3;
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bubble_in_ready got=%b want=0", in_ready); end
    step();
    bubble = 0; in_valid = 0; in_pc = 32'h9999; in_dslot = 0;
    total++; if (out_valid !== 1'b0 || out_pc !== 32'h3010 || out_dslot !== 1'b1) begin bad++; $display("FAIL bubble_tags got=%b/%h/%b want=0/3010/1", out_valid, out_pc, out_dslot); end
    total++; if (out_exc !== 5'd0 || out_tnew !== 2'd0 || out_data !== 64'd0) begin bad++; $display("FAIL bubble_zero got=%h/%0d/%h want=0", out_exc, out_tnew, out_data); end
    step(); step();
    total++; if (out_pc !== 32'h3010 || out_dslot !== 1'b1) begin bad++; $display("FAIL bubble_hold got=%h/%b want=3010/1", out_pc, out_dslot); end
  endtask

  task automatic test_flush();
    idle_inputs();
    @(negedge clk);
    in_valid = 1; in_pc = 32'h5000; in_dslot = 1;
    step();
`ifdef PIPE_SKID_EN
    in_pc = 32'h5004;
    step();
`endif
    in_valid = 0; flush = 1; bubble = 1;
    step();
    flush = 0; bubble = 0;
    #1;
    total++; if (out_valid !== 1'b0 || out_pc !== EX_PC) begin bad++; $display("FAIL flush_pc got=%b/%h want=0/4180", out_valid, out_pc); end
    total++; if (out_dslot !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL flush_state got=%b/%b want=0/1", out_dslot, in_ready); end
  endtask

  task automatic test_reset_flush();
    idle_inputs();
    @(negedge clk);
    in_valid = 1; in_pc = 32'h6000; in_data = 64'h66;
    step();
    rst = 0; flush = 1; in_pc = 32'h6004; in_data = 64'h77; out_ready = 1;
    step();
    rst = 1; flush = 0; in_valid = 0; out_ready = 0;
    #1;
    total++; if (out_pc !== RST_PC || out_valid !== 1'b0) begin bad++; $display("FAIL rstflush_pc got=%h/%b want=3000/0", out_pc, out_valid); end
    total++; if (out_data !== 64'd0 || in_ready !== 1'b1) begin bad++; $display("FAIL rstflush_clear got=%h/%b want=0/1", out_data, in_ready); end
  endtask

  task automatic test_random(input int n);
    ent_t e;
    logic exp_rdy, exp_ov, up, dn, tag_ok;
    logic [31:0] tag_pc;
    logic tag_ds;
    idle_inputs();
    q.delete();
    @(negedge clk);
    flush = 1;
    step();
    flush = 0;
    tag_ok = 1; tag_pc = EX_PC; tag_ds = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 39) == 0);
      bubble    = ($urandom_range(0, 29) == 0);
      in_data   = {$urandom, $urandom};
      in_pc     = $urandom;
      in_tnew   = 2'($urandom_range(0, 3));
      in_dslot  = 1'($urandom_range(0, 1));
      in_exc    = 5'($urandom_range(0, 31));
      #1;
      exp_ov = (q.size() > 0);
`ifdef PIPE_SKID_EN
      exp_rdy = !bubble && (q.size() < 2);
`else
      exp_rdy = !bubble && (q.size() == 0 || out_ready);
`endif
      total++; if (out_valid !== exp_ov) begin bad++; $display("FAIL rnd_valid cyc=%0d got=%b want=%b", i, out_valid, exp_ov); end
      total++; if (in_ready !== exp_rdy) begin bad++; $display("FAIL rnd_ready cyc=%0d got=%b want=%b", i, in_ready, exp_rdy); end
      if (exp_ov) begin
        total++;
        if (out_data !== q[0].d || out_pc !== q[0].pc || out_tnew !== q[0].t ||
            out_dslot !== q[0].ds || out_exc !== q[0].e) begin
          bad++;
          $display("FAIL rnd_entry cyc=%0d got=%h/%h/%0d/%b/%h want=%h/%h/%0d/%b/%h", i,
                   out_data, out_pc, out_tnew, out_dslot, out_exc,
                   q[0].d, q[0].pc, q[0].t, q[0].ds, q[0].e);
        end
      end else if (tag_ok) begin
        total++;
        if (out_pc !== tag_pc || out_dslot !== tag_ds) begin
          bad++; $display("FAIL rnd_tag cyc=%0d got=%h/%b want=%h/%b", i, out_pc, out_dslot, tag_pc, tag_ds);
        end
      end
      up = in_valid && exp_rdy;
      dn = exp_ov && out_ready;
      e = '{d: in_data, pc: in_pc, t: dec_model(in_tnew), ds: in_dslot, e: in_exc};
      @(posedge clk);
      if (flush) begin
        q.delete(); tag_ok = 1; tag_pc = EX_PC; tag_ds = 0;
      end else if (bubble) begin
        q.delete(); tag_ok = 1; tag_pc = e.pc; tag_ds = e.ds;
      end else begin
        if (dn) void'(q.pop_front());
        if (up) begin q.push_back(e); tag_ok = 0; end
      end
    end
    @(negedge clk);
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    rst = 0;
    test_reset();
    test_basic();
    test_backpressure();
    test_bubble();
    test_flush();
    test_reset_flush();
    test_random(2000);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
